i2c_wave_gen: RTL and testbench

I2C_WAVE_GEN -- requirements
Module: i2c_wave_gen

---
 rtl/i2c_wave_pkg.sv | 24 ++
 rtl/i2c_quarter_tick.sv | 36 +++
 rtl/i2c_wave_gen.sv | 171 +++++++++++++++++
 tb/tb_i2c_wave_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_wave_pkg.sv
// i2c_wave_pkg
// Shared definitions for the I2C byte waveform generator:
//   state_t       - sequencer states
//   Q0..Q3        - quarter-phase indices within one SCL period
//   QDIV_DEFAULT  - default clk cycles per quarter SCL period
package i2c_wave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // 100 kHz SCL from a 100 MHz clk
    localparam int QDIV_DEFAULT = 250;

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick
// Quarter-period divider: counts 0..QDIV-1 and pulses tick on the last count.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   restart  in   force counter to 0 (no tick while asserted)
//   freeze   in   hold counter value (no tick while asserted)
//   tick     out  one-cycle pulse ending each quarter
module i2c_quarter_tick
    import i2c_wave_pkg::*;
#(
    parameter int QDIV = QDIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic freeze,
    output logic tick
);

    localparam int CW = $clog2(QDIV);
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) & ~freeze & ~restart;

endmodule

// File: rtl/i2c_wave_gen.sv
// i2c_wave_gen
// Generates the SCL/SDA open-drain waveform for one I2C byte per command:
// optional START / repeated START, 8 data bits MSB first, ACK slot, optional STOP.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  idle and accepting
//   cmd_data   in   byte to transmit
//   cmd_start  in   precede byte with START
//   cmd_stop   in   follow ACK with STOP
//   sda_in     in   filtered SDA level (sampled in ACK slot)
//   scl_in     in   filtered SCL level (clock stretching only)
//   scl_oe     out  1 pulls SCL low
//   sda_oe     out  1 pulls SDA low
//   done       out  one-cycle completion pulse
//   ack_err    out  sampled ACK bit, 1 = NACK
// Build option: define I2C_WAVE_GEN_CLK_STRETCH_EN to freeze timing while a
// released SCL is still seen low.
module i2c_wave_gen
    import i2c_wave_pkg::*;
#(
    parameter int QDIV = QDIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       done,
    output logic       ack_err
);

    state_t     state, state_next;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       stop_req;
    logic       hold_low;   // SCL parked low after a byte without STOP
    logic       tick;
    logic       freeze;
    logic       accept;
    logic       last_tick;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign last_tick = tick & (quarter == Q3);

`ifdef I2C_WAVE_GEN_CLK_STRETCH_EN
    // Released SCL held low by a slave: wait before ending the quarter.
    assign freeze = (state != ST_IDLE) & ~scl_oe & ~scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign freeze = 1'b0;
`endif

    i2c_quarter_tick #(
        .QDIV(QDIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(cmd_ready),
        .freeze (freeze),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        case (state)
            ST_IDLE: begin
                scl_oe = hold_low;
                if (accept) begin
                    state_next = cmd_start ? ST_START : ST_BIT;
                end
            end
            ST_START: begin
                case (quarter)
                    Q0:      begin scl_oe = hold_low; sda_oe = 1'b0; end
                    Q1:      begin scl_oe = 1'b0;     sda_oe = 1'b0; end
                    Q2:      begin scl_oe = 1'b0;     sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b1;     sda_oe = 1'b1; end
                endcase
                if (last_tick) begin
                    state_next = ST_BIT;
                end
            end
            ST_BIT: begin
                scl_oe = (quarter == Q0) || (quarter == Q3);
                sda_oe = ~shift[7];
                if (last_tick && (bit_cnt == 3'd7)) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                scl_oe = (quarter == Q0) || (quarter == Q3);
                sda_oe = 1'b0;
                if (last_tick) begin
                    state_next = stop_req ? ST_STOP : ST_IDLE;
                end
            end
            ST_STOP: begin
                case (quarter)
                    Q0:      begin scl_oe = 1'b1; sda_oe = 1'b1; end
                    Q1:      begin scl_oe = 1'b0; sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b0; sda_oe = (quarter == Q2) ? 1'b0 : 1'b0; end
                endcase
                if (last_tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quarter  <= Q0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            stop_req <= 1'b0;
            hold_low <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                quarter  <= Q0;
                bit_cnt  <= 3'd0;
                shift    <= cmd_data;
                stop_req <= cmd_stop;
                ack_err  <= 1'b0;
            end else if (tick) begin
                quarter <= quarter + 2'd1;
                if ((state == ST_ACK) && (quarter == Q2)) begin
                    ack_err <= sda_in;
                end
                if (quarter == Q3) begin
                    if (state == ST_BIT) begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (state_next == ST_IDLE) begin
                        done     <= 1'b1;
                        // finishing from ACK means no STOP: keep the bus owned
                        hold_low <= (state == ST_ACK);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_wave_gen.sv
module tb_i2c_wave_gen;

    localparam int QDIV = 4;
`ifdef I2C_WAVE_GEN_CLK_STRETCH_EN
    localparam int STRETCH_DELAY = 20;
`else
    localparam int STRETCH_DELAY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_start;
    logic       cmd_stop;
    logic       sda_in;
    logic       scl_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       done;
    logic       ack_err;

    logic slave_pull;
    logic stretch;
    logic hold_model;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // wired-AND bus: line is high unless someone pulls it
    assign sda_in = ~(sda_oe | slave_pull);
    assign scl_in = ~(scl_oe | stretch);

    i2c_wave_gen #(
        .QDIV(QDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .sda_in   (sda_in),
        .scl_in   (scl_in),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .done     (done),
        .ack_err  (ack_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {scl_oe, sda_oe} per quarter, straight from the waveform rules.
    task automatic build_wave(input logic [7:0] d, input bit s, input bit p,
                              output logic [1:0] q[$]);
        logic b;
        q = {};
        if (s) begin
            q.push_back({hold_model, 1'b0});
            q.push_back(2'b00);
            q.push_back(2'b01);
            q.push_back(2'b11);
        end
        for (int i = 7; i >= 0; i--) begin
            b = ~d[i];
            q.push_back({1'b1, b});
            q.push_back({1'b0, b});
            q.push_back({1'b0, b});
            q.push_back({1'b1, b});
        end
        q.push_back(2'b10);
        q.push_back(2'b00);
        q.push_back(2'b00);
        q.push_back(2'b10);
        if (p) begin
            q.push_back(2'b11);
            q.push_back(2'b01);
            q.push_back(2'b00);
            q.push_back(2'b00);
        end
    endtask

    task automatic issue(input logic [7:0] d, input bit s, input bit p, input bit nack);
        int w;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            step();
            w++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        chk("idle_scl", {31'd0, scl_oe}, {31'd0, hold_model});
        chk("idle_sda", {31'd0, sda_oe}, 32'd0);
        cmd_valid  = 1'b1;
        cmd_data   = d;
        cmd_start  = s;
        cmd_stop   = p;
        slave_pull = ~nack;
        step();
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        chk("busy", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] d, input bit s, input bit p, input bit nack,
                           input bit do_stretch);
        logic [1:0] q[$];
        int exp_len;
        int c;
        int st_at;
        build_wave(d, s, p, q);
        exp_len = q.size() * QDIV;
        issue(d, s, p, nack);
        if (!do_stretch) begin
            for (int k = 0; k < exp_len; k++) begin
                if (k > 0) step();
                chk("scl_oe", {31'd0, scl_oe}, {31'd0, q[k / QDIV][1]});
                chk("sda_oe", {31'd0, sda_oe}, {31'd0, q[k / QDIV][0]});
                chk("done_early", {31'd0, done}, 32'd0);
                // offers while busy must be ignored
                if (k == 40) cmd_valid = 1'b1;
                if (k == 48) cmd_valid = 1'b0;
            end
            step();
        end else begin
            st_at = QDIV * (4 * int'(s) + 4 * 2 + 1);
            c = 0;
            while (!done && c < 2000) begin
                if (c == st_at) stretch = 1'b1;
                if (c == st_at + 20) stretch = 1'b0;
                step();
                c++;
            end
            stretch = 1'b0;
            chk("stretch_len", c, exp_len + STRETCH_DELAY);
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("ack_err", {31'd0, ack_err}, {31'd0, nack});
        hold_model = ~p;
        chk("end_scl", {31'd0, scl_oe}, {31'd0, hold_model});
        chk("end_sda", {31'd0, sda_oe}, 32'd0);
        step();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("ack_hold", {31'd0, ack_err}, {31'd0, nack});
    endtask

    task automatic reset_mid_byte();
        int seen;
        issue(8'hC3, 1'b1, 1'b1, 1'b0);
        // into bit 3, one cycle past its Q1 start
        for (int k = 0; k < QDIV * (4 + 4 * 3 + 1) + 1; k++) step();
        rst = 1'b1;
        step();
        chk("rst_scl", {31'd0, scl_oe}, 32'd0);
        chk("rst_sda", {31'd0, sda_oe}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        hold_model = 1'b0;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (done) seen++;
        end
        chk("no_done_after_rst", seen, 0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = 8'h00;
        cmd_start  = 1'b0;
        cmd_stop   = 1'b0;
        slave_pull = 1'b0;
        stretch    = 1'b0;
        hold_model = 1'b0;
        repeat (3) step();
        chk("reset_scl", {31'd0, scl_oe}, 32'd0);
        chk("reset_sda", {31'd0, sda_oe}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ack", {31'd0, ack_err}, 32'd0);
        rst = 1'b0;
        step();

        run_cmd(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        run_cmd(8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        run_cmd(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(8'h51, 1'b1, 1'b1, 1'b1, 1'b0);
        run_cmd(8'h96, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) step();
            run_cmd(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        reset_mid_byte();
        run_cmd(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
